// File: rtl/sum_display_scan_pkg.sv
// ============================================================================
// Module : sum_display_pkg
// Brief  : Shared types and segment constants for the sum display scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sum_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [2:0] DD_LAST_STEP = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sum_display_scan_if.sv
// ============================================================================
// Module : sum_display_scan_if
// Brief  : Load/result handshake and display pins of the sum display scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sum_display_scan_if;
    logic       load;
    logic [4:0] result;
    logic       busy;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (output load, output result, input busy, input seg, input an);
    modport slave  (input load, input result, output busy, output seg, output an);
endinterface

`default_nettype wire

// File: rtl/sum_display_scan_seg7_decoder.sv
// ============================================================================
// Module : seg7_decoder
// Brief  : BCD digit to active-low 7-segment pattern; non-BCD codes blank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
    import sum_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_LUT[0];
            4'd1:    seg = SEG_LUT[1];
            4'd2:    seg = SEG_LUT[2];
            4'd3:    seg = SEG_LUT[3];
            4'd4:    seg = SEG_LUT[4];
            4'd5:    seg = SEG_LUT[5];
            4'd6:    seg = SEG_LUT[6];
            4'd7:    seg = SEG_LUT[7];
            4'd8:    seg = SEG_LUT[8];
            4'd9:    seg = SEG_LUT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sum_display_scan.sv
// ============================================================================
// Module : sum_display_scan
// Brief  : Captures a 5-bit sum, converts it to BCD by double-dabble and
//          scans it onto a 2-digit common-anode 7-segment display.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sum_display_scan
    import sum_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
)(
    input  wire              clk,
    input  wire              rst_n,
    sum_display_scan_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(SCAN_DIV - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_finish;

    logic [4:0]       r_shreg;
    logic [7:0]       r_bcd;
    logic [2:0]       r_step;
    logic             r_busy;
    logic [3:0]       r_tens;
    logic [3:0]       r_units;
    logic             r_shown;
    logic [CNT_W-1:0] r_presc;
    logic             r_sel;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;

    logic [7:0]       w_bcd_adj;
    logic [7:0]       w_bcd_next;
    logic [4:0]       w_shreg_next;
    logic             w_dd_unused;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_an_next;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE, SHOW: begin
                if (bus.load) begin
                    w_accept     = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (r_step == DD_LAST_STEP) begin
                    w_finish     = 1'b1;
                    w_state_next = SHOW;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // One shift/add-3 step: correct each nibble, then shift {bcd, shreg} left.
    always_comb begin
        w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        {w_dd_unused, w_bcd_next, w_shreg_next} = {w_bcd_adj, r_shreg, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_bcd   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_tens  <= '0;
            r_units <= '0;
            r_shown <= 1'b0;
        end else if (w_accept) begin
            r_shreg <= bus.result;
            r_bcd   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == CONV) begin
            r_shreg <= w_shreg_next;
            r_bcd   <= w_bcd_next;
            r_step  <= r_step + 3'd1;
            if (w_finish) begin
                r_tens  <= w_bcd_next[7:4];
                r_units <= w_bcd_next[3:0];
                r_shown <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_sel   <= 1'b0;
        end else if (r_shown) begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_sel   <= ~r_sel;
            end else begin
                r_presc <= r_presc + CNT_W'(1);
            end
        end
    end

    assign w_digit = r_sel ? r_tens : r_units;

    seg7_decoder u_dec (
        .bcd (w_digit),
        .seg (w_seg_dec)
    );

    // Leading-zero suppression on the tens digit.
    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = 2'b11;
        if (r_shown) begin
            if (r_sel) begin
                w_an_next = 2'b01;
                if (r_tens != 4'd0) w_seg_next = w_seg_dec;
            end else begin
                w_an_next  = 2'b10;
                w_seg_next = w_seg_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 2'b11;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.busy = r_busy;
    assign bus.seg  = r_seg;
    assign bus.an   = r_an;

endmodule

`default_nettype wire
